// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: FSM encoding and line levels.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Prescale counter: bit_tick_o marks the last clock of each PRESCALE-long bit period.
module uart_bit_timer #(
    parameter int PRESCALE = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear_i,
    output logic bit_tick_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_tick_o = (cnt_q == LAST);

    // clear_i restarts the period so every state begins on a fresh bit boundary
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || bit_tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity,
// STOP_BITS stop bits, each held PRESCALE clocks. Handshake: a word is accepted on a rising
// edge where data_valid=1 and busy=0; data_valid is ignored while busy=1.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] Parallel_data,
    input  logic                  data_valid,
    input  logic                  parity_EN,
    input  logic                  parity_type,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  frame_done,
    output state_t                state_dbg_o
);

    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_WIDTH - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    stop_q, stop_d;
    logic                    tx_q, tx_d;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    pen_q;
    logic                    par_q;
    logic                    accept;
    logic                    bit_tick;
    logic                    timer_clear;

    assign accept      = (state_q == S_IDLE) && data_valid;
    assign timer_clear = (state_d != state_q) || (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign TX_OUT      = tx_q;
    assign state_dbg_o = state_q;

    uart_bit_timer #(.PRESCALE(PRESCALE)) u_bit_timer (
        .CLK        (CLK),
        .RST        (RST),
        .clear_i    (timer_clear),
        .bit_tick_o (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        stop_d     = stop_q;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = pen_q ? S_PARITY : S_STOP;
                        idx_d   = '0;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    if (stop_q == LAST_STOP) begin
                        state_d    = S_IDLE;
                        frame_done = 1'b1;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The line level is derived from the next state so TX_OUT changes together with the FSM
    always_comb begin
        tx_d = IDLE_LEVEL;
        case (state_d)
            S_START:  tx_d = START_LEVEL;
            S_DATA:   tx_d = data_q[idx_d];
            S_PARITY: tx_d = par_q;
            default:  tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= IDLE_LEVEL;
            data_q  <= '0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            if (accept) begin
                data_q <= Parallel_data;
                pen_q  <= parity_EN;
                par_q  <= (^Parallel_data) ^ parity_type;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three parameterisations driven from scenario tasks, per-cycle scoreboard.
module tb_uart_tx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [7:0] d0, d1;
    logic [4:0] d2;
    logic v0, v1, v2, pe0, pe1, pe2, pt0, pt1, pt2;
    logic tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
    uart_pkg::state_t st0, st1, st2;

    logic [2:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    uart_tx_param #(.DATA_WIDTH(8), .PRESCALE(1), .STOP_BITS(1)) u0 (
        .CLK(clk), .RST(rst_n), .Parallel_data(d0), .data_valid(v0), .parity_EN(pe0),
        .parity_type(pt0), .TX_OUT(tx0), .busy(busy0), .frame_done(done0), .state_dbg_o(st0)
    );

    uart_tx_param #(.DATA_WIDTH(8), .PRESCALE(4), .STOP_BITS(2)) u1 (
        .CLK(clk), .RST(rst_n), .Parallel_data(d1), .data_valid(v1), .parity_EN(pe1),
        .parity_type(pt1), .TX_OUT(tx1), .busy(busy1), .frame_done(done1), .state_dbg_o(st1)
    );

    uart_tx_param #(.DATA_WIDTH(5), .PRESCALE(1), .STOP_BITS(2)) u2 (
        .CLK(clk), .RST(rst_n), .Parallel_data(d2), .data_valid(v2), .parity_EN(pe2),
        .parity_type(pt2), .TX_OUT(tx2), .busy(busy2), .frame_done(done2), .state_dbg_o(st2)
    );

    // Expected per-cycle {busy, tx, frame_done} for one frame, followed by one idle cycle.
    function automatic void push_frame(input logic [8:0] data, input int dw, input int ps,
                                       input int sb, input logic pen, input logic ptype);
        logic bits[$];
        logic par;
        par = ptype;
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            bits.push_back(data[i]);
            par ^= data[i];
        end
        if (pen) bits.push_back(par);
        for (int i = 0; i < sb; i++) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int p = 0; p < ps; p++) begin
                exp_q.push_back({1'b1, bits[b], (b == bits.size() - 1) && (p == ps - 1)});
            end
        end
        exp_q.push_back(3'b010);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        v0 = 0; v1 = 0; v2 = 0;
        d0 = 8'h00; d1 = 8'h00; d2 = 5'h00;
        pe0 = 0; pe1 = 0; pe2 = 0; pt0 = 0; pt1 = 0; pt2 = 0;
        repeat (3) @(negedge clk);
        checks += 6;
        if ({busy0, tx0, done0} !== 3'b010) begin errors++; $display("FAIL reset_u0: got %b expected 010", {busy0, tx0, done0}); end
        if ({busy1, tx1, done1} !== 3'b010) begin errors++; $display("FAIL reset_u1: got %b expected 010", {busy1, tx1, done1}); end
        if ({busy2, tx2, done2} !== 3'b010) begin errors++; $display("FAIL reset_u2: got %b expected 010", {busy2, tx2, done2}); end
        if (st0 !== uart_pkg::S_IDLE) begin errors++; $display("FAIL reset_state_u0: got %0d expected 0", st0); end
        if (st1 !== uart_pkg::S_IDLE) begin errors++; $display("FAIL reset_state_u1: got %0d expected 0", st1); end
        if (st2 !== uart_pkg::S_IDLE) begin errors++; $display("FAIL reset_state_u2: got %0d expected 0", st2); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frames();
        logic [7:0] dv[3] = '{8'hA5, 8'hA5, 8'h00};
        logic       pe[3] = '{1'b1, 1'b1, 1'b0};
        logic       pt[3] = '{1'b0, 1'b1, 1'b0};
        int         lens[3] = '{11, 11, 10};
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            int busy_cnt = 0;
            @(negedge clk);
            d0 = dv[k]; pe0 = pe[k]; pt0 = pt[k]; v0 = 1'b1;
            push_frame({1'b0, dv[k]}, 8, 1, 1, pe[k], pt[k]);
            @(negedge clk);
            v0 = 1'b0;
            while (exp_q.size() > 0) begin
                logic [2:0] exp = exp_q.pop_front();
                checks++;
                if ({busy0, tx0, done0} !== exp) begin
                    errors++;
                    $display("FAIL basic_%0d cyc %0d: got busy/tx/done=%b expected %b", k, n, {busy0, tx0, done0}, exp);
                end
                if (busy0) busy_cnt++;
                n++;
                @(negedge clk);
            end
            checks++;
            if (busy_cnt != lens[k]) begin
                errors++;
                $display("FAIL basic_len_%0d: got %0d busy cycles expected %0d", k, busy_cnt, lens[k]);
            end
        end
    endtask

    task automatic test_prescale();
        int n = 0;
        int busy_cnt = 0;
        @(negedge clk);
        d1 = 8'h3C; pe1 = 1'b0; pt1 = 1'b0; v1 = 1'b1;
        push_frame({1'b0, 8'h3C}, 8, 4, 2, 1'b0, 1'b0);
        @(negedge clk);
        v1 = 1'b0;
        while (exp_q.size() > 0) begin
            logic [2:0] exp = exp_q.pop_front();
            checks++;
            if ({busy1, tx1, done1} !== exp) begin
                errors++;
                $display("FAIL prescale cyc %0d: got busy/tx/done=%b expected %b", n, {busy1, tx1, done1}, exp);
            end
            if (busy1) busy_cnt++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (busy_cnt != 44) begin
            errors++;
            $display("FAIL prescale_len: got %0d busy cycles expected 44", busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        @(negedge clk);
        d0 = 8'h11; pe0 = 1'b1; pt0 = 1'b0; v0 = 1'b1;
        push_frame({1'b0, 8'h11}, 8, 1, 1, 1'b1, 1'b0);
        push_frame({1'b0, 8'h22}, 8, 1, 1, 1'b1, 1'b1);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            logic [2:0] exp = exp_q.pop_front();
            checks++;
            if ({busy0, tx0, done0} !== exp) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got busy/tx/done=%b expected %b", n, {busy0, tx0, done0}, exp);
            end
            if (n == 3) begin d0 = 8'($urandom_range(0, 255)); pt0 = 1'b1; pe0 = 1'b0; end
            if (n == 6) begin d0 = 8'h22; pt0 = 1'b1; pe0 = 1'b1; end
            if (n == 14) begin d0 = 8'($urandom_range(0, 255)); pt0 = 1'b0; pe0 = 1'b0; end
            if (n == 20) v0 = 1'b0;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        @(negedge clk);
        d0 = 8'hA5; pe0 = 1'b0; pt0 = 1'b0; v0 = 1'b1;
        push_frame({1'b0, 8'hA5}, 8, 1, 1, 1'b0, 1'b0);
        @(negedge clk);
        v0 = 1'b0;
        while (n <= 4) begin
            logic [2:0] exp = exp_q.pop_front();
            checks++;
            if ({busy0, tx0, done0} !== exp) begin
                errors++;
                $display("FAIL pre_abort cyc %0d: got busy/tx/done=%b expected %b", n, {busy0, tx0, done0}, exp);
            end
            n++;
            if (n <= 4) @(negedge clk);
        end
        exp_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        checks += 2;
        if ({busy0, tx0, done0} !== 3'b010) begin
            errors++;
            $display("FAIL abort_outputs: got busy/tx/done=%b expected 010", {busy0, tx0, done0});
        end
        if (st0 !== uart_pkg::S_IDLE) begin
            errors++;
            $display("FAIL abort_state: got %0d expected 0", st0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        d0 = 8'h5A; pe0 = 1'b1; pt0 = 1'b1; v0 = 1'b1;
        push_frame({1'b0, 8'h5A}, 8, 1, 1, 1'b1, 1'b1);
        @(negedge clk);
        v0 = 1'b0;
        n = 0;
        while (exp_q.size() > 0) begin
            logic [2:0] exp = exp_q.pop_front();
            checks++;
            if ({busy0, tx0, done0} !== exp) begin
                errors++;
                $display("FAIL post_abort cyc %0d: got busy/tx/done=%b expected %b", n, {busy0, tx0, done0}, exp);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_dw5();
        int n = 0;
        int busy_cnt = 0;
        @(negedge clk);
        d2 = 5'b10110; pe2 = 1'b1; pt2 = 1'b1; v2 = 1'b1;
        push_frame({4'b0, 5'b10110}, 5, 1, 2, 1'b1, 1'b1);
        @(negedge clk);
        v2 = 1'b0;
        while (exp_q.size() > 0) begin
            logic [2:0] exp = exp_q.pop_front();
            checks++;
            if ({busy2, tx2, done2} !== exp) begin
                errors++;
                $display("FAIL dw5 cyc %0d: got busy/tx/done=%b expected %b", n, {busy2, tx2, done2}, exp);
            end
            if (busy2) busy_cnt++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (busy_cnt != 9) begin
            errors++;
            $display("FAIL dw5_len: got %0d busy cycles expected 9", busy_cnt);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int n = 0;
            logic [7:0] w = 8'($urandom_range(0, 255));
            logic pe = 1'($urandom_range(0, 1));
            logic pt = 1'($urandom_range(0, 1));
            @(negedge clk);
            d1 = w; pe1 = pe; pt1 = pt; v1 = 1'b1;
            push_frame({1'b0, w}, 8, 4, 2, pe, pt);
            @(negedge clk);
            v1 = 1'b0;
            while (exp_q.size() > 0) begin
                logic [2:0] exp = exp_q.pop_front();
                checks++;
                if ({busy1, tx1, done1} !== exp) begin
                    errors++;
                    $display("FAIL random_%0d data %h cyc %0d: got busy/tx/done=%b expected %b", k, w, n, {busy1, tx1, done1}, exp);
                end
                n++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frames();
        test_prescale();
        test_back_to_back();
        test_reset_mid_frame();
        test_dw5();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
